// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Constants, the registered-flag bundle and the noise LFSR step function
//   shared by video_timing_gen and noise_lfsr.
package video_timing_pkg;

    localparam logic [8:0]  V_TOTAL_NTSC  = 9'd262;
    localparam logic [8:0]  V_TOTAL_PAL   = 9'd312;
    localparam logic [8:0]  VS_START_NTSC = 9'd244;
    localparam logic [8:0]  VS_START_PAL  = 9'd270;
    localparam logic [8:0]  VS_LEN        = 9'd3;
    localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;

    typedef struct packed {
        logic hblank;
        logic hsync;
        logic vblank;
        logic vsync;
    } vflags_t;

    localparam vflags_t FLAGS_RESET = '{hblank: 1'b1, hsync: 1'b0, vblank: 1'b1, vsync: 1'b0};

    // Right-shifting Galois form, taps 32,22,2,1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/video_timing_gen_noise_lfsr.sv
// noise_lfsr
//   32-bit Galois LFSR noise source with a registered 8-bit luma output.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     ce         : pixel enable; luma updates only on ce
//     en         : pixel being presented is active; the LFSR steps only then
//     luma       : low byte of the stepped state, 0 for blanked pixels
module noise_lfsr
    import video_timing_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2B3D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       en,
    output logic [7:0] luma
);

    logic [31:0] state;
    logic [31:0] state_next;

    always_comb begin
        state_next = lfsr_step(state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
            luma  <= '0;
        end else if (ce) begin
            if (en) begin
                state <= state_next;
                luma  <= state_next[7:0];
            end else begin
                luma  <= '0;
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   15 kHz NTSC/PAL raster (or 31 kHz scandoubled) with pixel enable,
//   sync/blank flags and LFSR noise luma. All outputs are registered and
//   change together on the edge that raises ce_pix.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     pal         : 0 = NTSC 262 lines, 1 = PAL 312 lines (taken at frame wrap)
//     scandouble  : 1 = each line emitted twice at half pixel period (taken at frame wrap)
//     ce_pix      : one-clock pixel enable
//     HBlank, HSync, VBlank, VSync : raster flags, active high
//     video       : 8-bit noise luma, 0 while blanked
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CE_DIV    = 8,
    parameter int unsigned H_ACTIVE  = 320,
    parameter int unsigned H_TOTAL   = 400,
    parameter int unsigned HS_START  = 336,
    parameter int unsigned HS_END    = 368,
    parameter int unsigned V_ACTIVE  = 240,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2B3D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic [7:0] video
);

    localparam int unsigned   DW          = $clog2(CE_DIV);
    localparam logic [DW-1:0] DIV_LAST_15 = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST_31 = DW'(CE_DIV / 2 - 1);
    localparam logic [8:0]    H_LAST      = 9'(H_TOTAL - 1);
    localparam logic [8:0]    H_ACT       = 9'(H_ACTIVE);
    localparam logic [8:0]    HS_ON       = 9'(HS_START);
    localparam logic [8:0]    HS_OFF      = 9'(HS_END);
    localparam logic [8:0]    V_ACT       = 9'(V_ACTIVE);

    logic [DW-1:0] divider;
    logic [8:0]    hcnt;
    logic [8:0]    vcnt;
    logic          dbl_phase;
    logic          pal_r;
    logic          sd_r;
    vflags_t       flags;

    logic [DW-1:0] div_last;
    logic [8:0]    v_last;
    logic [8:0]    vs_start;
    logic          ce;
    logic          h_wrap;
    logic          line_adv;
    logic          v_wrap;
    logic          active;
    vflags_t       flags_next;

    // Flags decode the pixel about to be presented; the counters then move on.
    always_comb begin
        div_last   = sd_r ? DIV_LAST_31 : DIV_LAST_15;
        v_last     = (pal_r ? V_TOTAL_PAL : V_TOTAL_NTSC) - 9'd1;
        vs_start   = pal_r ? VS_START_PAL : VS_START_NTSC;
        ce         = (divider == div_last);
        h_wrap     = (hcnt == H_LAST);
        // In scandouble mode the second copy of a line closes it.
        line_adv   = h_wrap && (!sd_r || dbl_phase);
        v_wrap     = line_adv && (vcnt == v_last);

        flags_next        = FLAGS_RESET;
        flags_next.hblank = (hcnt >= H_ACT);
        flags_next.hsync  = (hcnt >= HS_ON) && (hcnt < HS_OFF);
        flags_next.vblank = (vcnt >= V_ACT);
        flags_next.vsync  = (vcnt >= vs_start) && (vcnt < vs_start + VS_LEN);
        active            = !flags_next.hblank && !flags_next.vblank;
    end

    // Mode latches only at frame wrap, which always coincides with ce, so the
    // divider is already restarting at 0 when a new divide ratio takes effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider   <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            dbl_phase <= 1'b0;
            pal_r     <= 1'b0;
            sd_r      <= 1'b0;
            flags     <= FLAGS_RESET;
            ce_pix    <= 1'b0;
        end else begin
            ce_pix <= ce;
            if (ce) begin
                divider <= '0;
                flags   <= flags_next;
                hcnt    <= h_wrap ? 9'd0 : hcnt + 9'd1;
                if (h_wrap && sd_r) begin
                    dbl_phase <= ~dbl_phase;
                end
                if (line_adv) begin
                    vcnt <= v_wrap ? 9'd0 : vcnt + 9'd1;
                end
                if (v_wrap) begin
                    pal_r <= pal;
                    sd_r  <= scandouble;
                end
            end else begin
                divider <= divider + 1'b1;
            end
        end
    end

    noise_lfsr #(
        .SEED (LFSR_SEED)
    ) u_noise (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .en    (active),
        .luma  (video)
    );

    assign HBlank = flags.hblank;
    assign HSync  = flags.hsync;
    assign VBlank = flags.vblank;
    assign VSync  = flags.vsync;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Scoreboard bench: the stimulus process generates whole frames of expected
//   pixels (cycle of ce_pix, flags, luma) from raster rules and queues them;
//   a monitor checks every clock against the queue and the held values.
module tb_video_timing_gen;

    localparam int unsigned CE_DIV   = 4;
    localparam int unsigned H_ACTIVE = 10;
    localparam int unsigned H_TOTAL  = 16;
    localparam int unsigned HS_START = 12;
    localparam int unsigned HS_END   = 14;
    localparam int unsigned V_ACTIVE = 240;
    localparam logic [31:0] SEED     = 32'hACE1_2B3D;
    localparam logic [31:0] MASK     = 32'h8020_0003;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pal = 1'b0;
    logic       scandouble = 1'b0;
    logic       ce_pix;
    logic       HBlank;
    logic       HSync;
    logic       VBlank;
    logic       VSync;
    logic [7:0] video;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CE_DIV    (CE_DIV),
        .H_ACTIVE  (H_ACTIVE),
        .H_TOTAL   (H_TOTAL),
        .HS_START  (HS_START),
        .HS_END    (HS_END),
        .V_ACTIVE  (V_ACTIVE),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .pal        (pal),
        .scandouble (scandouble),
        .ce_pix     (ce_pix),
        .HBlank     (HBlank),
        .HSync      (HSync),
        .VBlank     (VBlank),
        .VSync      (VSync),
        .video      (video)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  fl;   // {hblank, hsync, vblank, vsync}
        logic [7:0]  vid;
    } rec_t;

    rec_t        sbq[$];
    rec_t        last = '{cyc: 0, fl: 4'b1010, vid: 8'h00};
    int unsigned cyc;
    bit          mon_on = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] lfsr_m;
    int unsigned t_m;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [31:0] galois(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? MASK : 32'h0);
    endfunction

    function automatic int unsigned frame_lines(input bit p);
        return p ? 312 : 262;
    endfunction

    // Expected pixels for the first nlines source lines of a frame.
    task automatic push_frame(input bit p, input bit s, input int unsigned nlines);
        int unsigned vs0  = p ? 270 : 244;
        int unsigned div  = s ? CE_DIV / 2 : CE_DIV;
        int unsigned reps = s ? 2 : 1;
        for (int unsigned v = 0; v < nlines; v++) begin
            for (int unsigned r = 0; r < reps; r++) begin
                for (int unsigned h = 0; h < H_TOTAL; h++) begin
                    rec_t e;
                    bit   hb;
                    bit   vb;
                    hb    = (h >= H_ACTIVE);
                    vb    = (v >= V_ACTIVE);
                    t_m  += div;
                    e.cyc = t_m;
                    e.fl  = {hb, (h >= HS_START && h < HS_END), vb, (v >= vs0 && v < vs0 + 3)};
                    if (!hb && !vb) begin
                        lfsr_m = galois(lfsr_m);
                        e.vid  = lfsr_m[7:0];
                    end else begin
                        e.vid  = 8'h00;
                    end
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor
    initial begin
        rec_t e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                chk("reset_state", {19'd0, ce_pix, HBlank, HSync, VBlank, VSync, video},
                    {19'd0, 5'b01010, 8'h00});
                last.fl  = 4'b1010;
                last.vid = 8'h00;
            end else if (mon_on) begin
                if (ce_pix) begin
                    if (sbq.size() == 0) begin
                        chk("ce_pix_spurious", {31'd0, ce_pix}, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ce_pix_time", cyc, e.cyc);
                        chk("flags", {28'd0, HBlank, HSync, VBlank, VSync}, {28'd0, e.fl});
                        chk("video", {24'd0, video}, {24'd0, e.vid});
                        last = e;
                    end
                end else begin
                    if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                        chk("ce_pix_missing", {31'd0, ce_pix}, 32'd1);
                        last = sbq.pop_front();
                    end
                    chk("hold", {20'd0, HBlank, HSync, VBlank, VSync, video},
                        {20'd0, last.fl, last.vid});
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit          cp;
        bit          cs;
        bit          np;
        bit          ns;
        int unsigned t0;
        int unsigned chg;
        int unsigned vs0;
        // One source line always spans H_TOTAL*CE_DIV clocks in either mode.
        int unsigned lc = H_TOTAL * CE_DIV;

        lfsr_m = SEED;
        t_m    = 0;
        cp     = 1'b0;
        cs     = 1'b0;
        t0     = 0;
        repeat (4) @(negedge clk);
        push_frame(cp, cs, frame_lines(cp));
        rst    = 1'b0;
        mon_on = 1'b1;

        for (int f = 0; f < 3; f++) begin
            case (f)
                0:       begin np = 1'b1; ns = 1'b0; chg = 100; end
                1:       begin np = 1'b0; ns = 1'b1; chg = $urandom_range(20, 200); end
                default: begin np = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
                               chg = $urandom_range(20, 200); end
            endcase
            wait_cyc(t0 + chg * lc + $urandom_range(0, lc - 1));
            pal        = np;
            scandouble = ns;
            wait_cyc(t_m);
            t0 = t_m;
            cp = np;
            cs = ns;
            push_frame(cp, cs, frame_lines(cp));
        end

        // Asynchronous reset in the middle of the VSync lines.
        vs0 = cp ? 270 : 244;
        wait_cyc(t0 + (vs0 + 1) * lc + $urandom_range(0, lc / 2));
        #1;
        mon_on = 1'b0;
        rst    = 1'b1;
        sbq.delete();
        repeat (3) @(negedge clk);
        lfsr_m     = SEED;
        t_m        = 0;
        pal        = 1'b0;
        scandouble = 1'b0;
        push_frame(1'b0, 1'b0, 3);
        rst    = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < 8 * lc && sbq.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel source feeding the core's top-level video outputs (CE_PIXEL, VGA_HS/VS, VGA_DE, VGA_R/G/B colour masking).
- Generates a 15 kHz NTSC or PAL raster, or a 31 kHz raster when scandouble is set, with a one-clock pixel enable, sync/blank flags and an 8-bit LFSR noise luma.
- All outputs are registered and aligned to the same pixel-enable edge.

Parameters:
- CE_DIV, 8: clk cycles per pixel in 15 kHz mode; halved (CE_DIV/2) in scandouble mode. Must be even and ≥4.
- H_ACTIVE, 320: visible pixels per line.
- H_TOTAL, 400: pixels per line, including blanking.
- HS_START, 336: first pixel of HSync.
- HS_END, 368: first pixel after HSync.
- V_ACTIVE, 240: visible lines.
- LFSR_SEED, 32'hACE1_2B3D: LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  asynchronous, active-high reset
- pal  in  1  0=NTSC (262 lines), 1=PAL (312 lines)
- scandouble  in  1  1=31 kHz output; each source line is emitted twice
- ce_pix  out  1  one-clock pixel enable pulse
- HBlank  out  1  horizontal blanking
- HSync  out  1  horizontal sync, active high
- VBlank  out  1  vertical blanking
- VSync  out  1  vertical sync, active high
- video  out  8  noise luma; 0 while blanked

Behaviour:
- Reset (async assert, sync release): divider=0, hcnt=0, vcnt=0, dbl_phase=0, lfsr=LFSR_SEED, mode regs pal_r=0 and sd_r=0. Outputs: ce_pix=0, HBlank=1, VBlank=1, HSync=0, VSync=0, video=0.
- Divider: counts 0..div-1, where div = sd_r ? CE_DIV/2 : CE_DIV. The internal enable ce fires when divider==div-1.
- ce_pix is a registered copy of ce. All other outputs update on the same edge that raises ce_pix and hold for the whole pixel period.
- hcnt advances on ce and wraps at H_TOTAL-1 to 0.
- Line advance on hcnt wrap:
  - 15 kHz mode: vcnt advances every line.
  - Scandouble mode: dbl_phase toggles on every wrap; vcnt advances only when dbl_phase goes 1→0.
- vcnt wraps at V_TOTAL-1, where V_TOTAL = pal_r ? 312 : 262.
- pal_r and sd_r latch pal and scandouble only at frame wrap (hcnt wrap with vcnt → 0). Changes mid-frame take effect at the next frame; there are no partial lines. The divider restarts at 0 on a mode change.
- Flag decode (registered, computed from the counter values being presented):
  - HBlank = hcnt ≥ H_ACTIVE.
  - HSync = HS_START ≤ hcnt < HS_END.
  - VBlank = vcnt ≥ V_ACTIVE.
  - VSync: NTSC vcnt 244..246; PAL vcnt 270..272. In scandouble mode both emitted copies of those lines carry VSync, giving 6 output lines.
- LFSR: 32-bit Galois, taps 32,22,2,1 (mask 32'h8020_0003). Steps on ce only while active (!HBlank && !VBlank for the next pixel). video = lfsr[7:0] when active, else 0. The LFSR is never reseeded except by reset, and its state is continuous across frames.
- Arithmetic: hcnt is 9 bits, vcnt is 9 bits, the divider is $clog2(CE_DIV) bits. No counter exceeds its terminal value.
- Reset mid-line returns immediately to the reset values; the first ce_pix after release comes CE_DIV clocks later (pal_r=0, sd_r=0).

Decomposition:
- Package video_timing_pkg holds:
  - V_TOTAL_NTSC=262, V_TOTAL_PAL=312;
  - VS_START_NTSC=244, VS_START_PAL=270, VS_LEN=3;
  - LFSR_MASK=32'h8020_0003;
  - typedef struct {hblank, hsync, vblank, vsync} vflags_t.
- Sub-module noise_lfsr: 32-bit Galois LFSR with en and seed parameter, 8-bit output.

Test Plan:
- Reset release, NTSC, scandouble=0 -> first ce_pix exactly 8 clks after release; ce_pix period 8; HSync high 32 pixels starting at pixel 336; line = 3200 clks.
- NTSC frame -> 262 HSync pulses between VSync rising edges; VSync spans 3 lines (lines 244-246); VBlank high for 22 lines; frame = 838400 clks.
- pal=1 toggled at vcnt=100 -> current frame still 262 lines; next frame 312 lines with VSync at lines 270-272.
- scandouble=1 -> ce_pix period 4; line = 1600 clks; 524 HSync pulses per NTSC frame; VSync spans 6 output lines.
- Active pixels -> first active video = LFSR_SEED stepped once, low byte, matching the reference model; video==0 whenever HBlank|VBlank; the LFSR does not step during blanking (sequence continuity checked across a line boundary).
- Async reset asserted mid-VSync (no clk edge) -> VSync=0, HBlank=1, VBlank=1, video=0 immediately; after release the counters restart at 0,0.
